// File: rtl/matrix_key_scan_pkg.sv
// Shared constants and helpers for the 4x4 matrix key scanner.
//   NUM_ROWS / NUM_COLS : matrix geometry
//   KEY_CODE_W          : width of a key code, {row[1:0], col[1:0]}
//   ROW_IDLE_N          : row strobe pattern with no row driven
//   is_single_key()     : true when a key map holds exactly one pressed key
//   key_index()         : position of the set bit in a single-key map
package matrix_key_scan_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;
  localparam int KEY_CODE_W = 4;
  localparam int ROW_W      = 2;
  localparam logic [NUM_ROWS-1:0] ROW_IDLE_N = 4'b1111;

  typedef logic [NUM_KEYS-1:0] key_map_t;

  // Clearing the lowest set bit leaves zero only for a power of two.
  function automatic logic is_single_key(key_map_t m);
    logic single;
    single = (m != '0) && ((m & (m - key_map_t'(1))) == '0);
    return single;
  endfunction

  function automatic logic [KEY_CODE_W-1:0] key_index(key_map_t m);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (m[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/matrix_key_scan_if.sv
// Key event interface between the scanner and the consuming user logic.
//   key_code  : code of the reported key, stable while key_valid is high
//   key_valid : an unconsumed press event is held
//   key_ack   : consumer takes the event (only meaningful while key_valid)
//   key_down  : debounced map holds exactly one key
//   overrun   : sticky, an event was dropped while one was still pending
interface matrix_key_scan_if;
  import matrix_key_scan_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ack;
  logic                  key_down;
  logic                  overrun;

  modport master (
    output key_code, key_valid, key_down, overrun,
    input  key_ack
  );

  modport slave (
    input  key_code, key_valid, key_down, overrun,
    output key_ack
  );

endinterface

// File: rtl/matrix_key_scan_timer.sv
// mkscan_timer: row strobe timing for the key scanner.
//   clk, rst      : system clock, synchronous active-high reset
//   row_n         : one-cold row strobes (registered)
//   row           : index of the row currently driven
//   sample_stb    : last divider count of a row, columns have settled
//   frame_end_stb : sample_stb on the last row, snapshot is complete
module mkscan_timer
  import matrix_key_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_ROWS-1:0] row_n,
  output logic [ROW_W-1:0]    row,
  output logic                sample_stb,
  output logic                frame_end_stb
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [NUM_ROWS-1:0] row_n_q, row_n_d;

  // Divider wraps at SCAN_DIV-1 and moves the strobe to the next row.
  // row_n is decoded from the next row index so it leaves a flop glitch-free.
  always_comb begin
    sample_stb    = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end_stb = sample_stb && (row_q == ROW_W'(NUM_ROWS - 1));
    div_d         = div_q + DIV_W'(1);
    row_d         = row_q;
    if (sample_stb) begin
      div_d = '0;
      row_d = row_q + ROW_W'(1);
    end
    row_n_d = ROW_IDLE_N ^ (NUM_ROWS'(1) << row_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      row_q   <= '0;
      row_n_q <= ROW_IDLE_N ^ NUM_ROWS'(1);
    end else begin
      div_q   <= div_d;
      row_q   <= row_d;
      row_n_q <= row_n_d;
    end
  end

  assign row_n = row_n_q;
  assign row   = row_q;

endmodule

// File: rtl/matrix_key_scan.sv
// matrix_key_scan: active-scan driver and decoder for a 4x4 key matrix.
// Rows are strobed low one at a time, the active-low columns are synchronized
// and assembled into a whole-matrix snapshot, the snapshot is debounced over
// several identical frames, and a clean single-key press becomes one key code
// offered under a valid/ack handshake.
//   clk, rst : system clock, synchronous active-high reset
//   col_n    : asynchronous column inputs, low = key closed on the driven row
//   row_n    : one-cold row strobes
//   key_if   : key event interface (master side)
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int STABLE_SCANS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col_n,
  output logic [NUM_ROWS-1:0] row_n,
  matrix_key_scan_if.master   key_if
);

  localparam int CNT_W = $clog2(STABLE_SCANS + 1);

  logic [ROW_W-1:0]      row;
  logic                  sample_stb;
  logic                  frame_end_stb;

  logic [NUM_COLS-1:0]   col_meta_q, col_sync_q;
  key_map_t              snap_q, snap_d;
  key_map_t              prev_snap_q, prev_snap_d;
  key_map_t              deb_map_q, deb_map_d;
  logic [CNT_W-1:0]      stable_cnt_q, stable_cnt_d;
  logic                  evt_q, evt_d;
  logic [KEY_CODE_W-1:0] evt_code_q, evt_code_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_down_q, key_down_d;
  logic                  overrun_q, overrun_d;

  mkscan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .row_n         (row_n),
    .row           (row),
    .sample_stb    (sample_stb),
    .frame_end_stb (frame_end_stb)
  );

  // snap_d already contains the row 3 sample at frame end, so the frame
  // compare sees the complete snapshot in the same cycle it is captured.
  // The event is registered first and presented on the following clock.
  always_comb begin
    snap_d       = snap_q;
    prev_snap_d  = prev_snap_q;
    stable_cnt_d = stable_cnt_q;
    deb_map_d    = deb_map_q;
    evt_d        = 1'b0;
    evt_code_d   = evt_code_q;

    for (int r = 0; r < NUM_ROWS; r++) begin
      if (sample_stb && (row == ROW_W'(r))) begin
        snap_d[r*NUM_COLS +: NUM_COLS] = ~col_sync_q;
      end
    end

    if (frame_end_stb) begin
      prev_snap_d = snap_d;
      if (snap_d == prev_snap_q) begin
        if (stable_cnt_q != CNT_W'(STABLE_SCANS)) begin
          stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
      end else begin
        stable_cnt_d = '0;
      end
      if (stable_cnt_d == CNT_W'(STABLE_SCANS)) begin
        deb_map_d = snap_d;
        if ((deb_map_q == '0) && is_single_key(snap_d)) begin
          evt_d      = 1'b1;
          evt_code_d = key_index(snap_d);
        end
      end
    end

    key_down_d = is_single_key(deb_map_d);
  end

  // A new event wins over an ack in the same cycle; an event arriving while
  // the previous one is still unacknowledged is dropped and flagged.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (evt_q) begin
      if (!key_valid_q || key_if.key_ack) begin
        key_code_d  = evt_code_q;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_valid_q && key_if.key_ack) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q   <= '1;
      col_sync_q   <= '1;
      snap_q       <= '0;
      prev_snap_q  <= '0;
      stable_cnt_q <= '0;
      deb_map_q    <= '0;
      evt_q        <= 1'b0;
      evt_code_q   <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_down_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      col_meta_q   <= col_n;
      col_sync_q   <= col_meta_q;
      snap_q       <= snap_d;
      prev_snap_q  <= prev_snap_d;
      stable_cnt_q <= stable_cnt_d;
      deb_map_q    <= deb_map_d;
      evt_q        <= evt_d;
      evt_code_q   <= evt_code_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_down_q   <= key_down_d;
      overrun_q    <= overrun_d;
    end
  end

  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_down  = key_down_q;
  assign key_if.overrun   = overrun_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Testbench for matrix_key_scan with a short scan period. A keypad model
// shorts row r to column c for every pressed key; a frame-level reference
// model predicts which key maps get accepted and which press events result.
module tb_matrix_key_scan;
  import matrix_key_scan_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int STABLE_SCANS = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keys = '0;

  matrix_key_scan_if key_if ();

  matrix_key_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .STABLE_SCANS (STABLE_SCANS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .col_n  (col_n),
    .row_n  (row_n),
    .key_if (key_if)
  );

  always #5 clk = ~clk;

  // Keypad: a closed key pulls its column low while its row is strobed.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  int          assertCount = 0;
  int          failCount   = 0;
  int          ph          = 0;
  bit          autoAck     = 0;
  bit          frameDirty  = 0;
  logic [15:0] lastMap;
  logic [15:0] debModel;
  bit          haveLast;
  int          runLen;
  int          expQ[$];
  int          obsQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] map);
    keys = map;
  endtask

  // Reference: a map is accepted once seen in STABLE_SCANS+1 consecutive
  // frames (reset counts as one all-released frame). A press event is the
  // accepted map changing from nothing pressed to exactly one key.
  task automatic resetModel();
    lastMap  = '0;
    haveLast = 1;
    runLen   = 1;
    debModel = '0;
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic modelFrame(input logic [15:0] map, input bit dirty);
    logic [15:0] oldDeb;
    if (dirty) begin
      haveLast = 0;
      runLen   = 0;
    end else if (haveLast && map == lastMap) begin
      runLen++;
    end else begin
      runLen   = 1;
      lastMap  = map;
      haveLast = 1;
    end
    if (runLen >= STABLE_SCANS + 1) begin
      oldDeb   = debModel;
      debModel = map;
      if (oldDeb == 0 && $countones(map) == 1) begin
        for (int i = 0; i < 16; i++) if (map[i]) expQ.push_back(i);
      end
    end
  endtask

  task automatic serviceAck();
    if (key_if.key_ack) begin
      key_if.key_ack = 1'b0;
    end else if (key_if.key_valid === 1'b1) begin
      obsQ.push_back(int'(key_if.key_code));
      key_if.key_ack = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ph++;
    if (autoAck) serviceAck();
    if (ph == FRAME) begin
      ph = 0;
      modelFrame(keys, frameDirty);
      frameDirty = 0;
    end
  endtask

  task automatic finishFrame();
    while (ph != 0) tick();
  endtask

  task automatic runFrames(input logic [15:0] map, input int n);
    applyStimulus(map);
    repeat (n * FRAME) tick();
  endtask

  // Chatter between two maps for a frame and a half, then settle on the second.
  task automatic bounceFrames(input logic [15:0] from, input logic [15:0] to);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i < FRAME + FRAME / 2) applyStimulus($urandom_range(0, 1) ? from : to);
      else applyStimulus(to);
      frameDirty = 1;
      tick();
    end
  endtask

  task automatic ackPulse();
    key_if.key_ack = 1'b1;
    tick();
    key_if.key_ack = 1'b0;
  endtask

  function automatic int firstObs();
    return (obsQ.size() > 0) ? obsQ[0] : -1;
  endfunction

  initial begin
    logic [15:0] map;
    logic [3:0]  expRow;
    int          n;
    int          a;
    int          b;

    key_if.key_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ph  = 0;
    resetModel();

    $display("[TB] test 1: reset state and row scanning");
    checkOutput("reset row_n", row_n, 4'b1110);
    checkOutput("reset key_code", key_if.key_code, 0);
    checkOutput("reset key_valid", key_if.key_valid, 0);
    checkOutput("reset key_down", key_if.key_down, 0);
    checkOutput("reset overrun", key_if.overrun, 0);
    for (int j = 1; j <= FRAME; j++) begin
      tick();
      expRow = 4'b1111 ^ (4'b0001 << ((j / SCAN_DIV) % 4));
      checkOutput("row_n cycle", row_n, expRow);
    end
    runFrames(16'h0000, 4);
    checkOutput("idle key_valid", key_if.key_valid, 0);
    checkOutput("idle key_down", key_if.key_down, 0);

    $display("[TB] test 2: clean press of r2c1");
    autoAck = 0;
    runFrames(16'h0200, STABLE_SCANS + 1);
    tick();
    checkOutput("t2 key_valid", key_if.key_valid, 1);
    checkOutput("t2 key_code", key_if.key_code, 9);
    checkOutput("t2 key_down", key_if.key_down, 1);
    ackPulse();
    checkOutput("t2 valid after ack", key_if.key_valid, 0);
    finishFrame();
    runFrames(16'h0200, 4);
    checkOutput("t2 no repeat", key_if.key_valid, 0);
    runFrames(16'h0000, 4);
    checkOutput("t2 release key_down", key_if.key_down, 0);
    expQ.delete();

    $display("[TB] test 3: bouncing press and release of r0c3");
    autoAck = 1;
    obsQ.delete();
    bounceFrames(16'h0000, 16'h0008);
    runFrames(16'h0008, 4);
    checkOutput("t3 event count", obsQ.size(), 1);
    checkOutput("t3 event code", firstObs(), 3);
    checkOutput("t3 model count", obsQ.size(), expQ.size());
    checkOutput("t3 key_down", key_if.key_down, 1);
    obsQ.delete();
    expQ.delete();
    bounceFrames(16'h0008, 16'h0000);
    runFrames(16'h0000, 4);
    checkOutput("t3 release key_down", key_if.key_down, 0);
    checkOutput("t3 release events", obsQ.size(), 0);

    $display("[TB] test 4: two-key rollover");
    obsQ.delete();
    expQ.delete();
    runFrames(16'h8010, 4);
    checkOutput("t4 dual key_down", key_if.key_down, 0);
    checkOutput("t4 dual events", obsQ.size(), 0);
    runFrames(16'h0010, 4);
    checkOutput("t4 partial events", obsQ.size(), 0);
    checkOutput("t4 partial key_down", key_if.key_down, ($countones(debModel) == 1));
    runFrames(16'h0000, 4);
    runFrames(16'h0010, 4);
    checkOutput("t4 repress events", obsQ.size(), 1);
    checkOutput("t4 repress code", firstObs(), 4);
    runFrames(16'h0000, 4);

    $display("[TB] test 5: overrun and ack colliding with a new event");
    autoAck = 0;
    runFrames(16'h0020, 4);
    checkOutput("t5 first valid", key_if.key_valid, 1);
    checkOutput("t5 first code", key_if.key_code, 5);
    checkOutput("t5 no overrun yet", key_if.overrun, 0);
    runFrames(16'h0000, 4);
    runFrames(16'h0400, 4);
    checkOutput("t5 code kept", key_if.key_code, 5);
    checkOutput("t5 still valid", key_if.key_valid, 1);
    checkOutput("t5 overrun", key_if.overrun, 1);
    runFrames(16'h0000, 4);
    runFrames(16'h0400, STABLE_SCANS + 1);
    ackPulse();
    checkOutput("t5 ack+event valid", key_if.key_valid, 1);
    checkOutput("t5 ack+event code", key_if.key_code, 10);
    ackPulse();
    checkOutput("t5 final ack", key_if.key_valid, 0);
    checkOutput("t5 overrun sticky", key_if.overrun, 1);
    finishFrame();

    $display("[TB] test 6: reset mid-frame with an event pending");
    runFrames(16'h0000, 4);
    runFrames(16'h0040, 4);
    checkOutput("t6 pending valid", key_if.key_valid, 1);
    checkOutput("t6 pending code", key_if.key_code, 6);
    repeat (2 * SCAN_DIV + 1) tick();
    checkOutput("t6 row 2 strobe", row_n, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ph  = 0;
    resetModel();
    checkOutput("t6 rst row_n", row_n, 4'b1110);
    checkOutput("t6 rst key_valid", key_if.key_valid, 0);
    checkOutput("t6 rst key_code", key_if.key_code, 0);
    checkOutput("t6 rst key_down", key_if.key_down, 0);
    checkOutput("t6 rst overrun", key_if.overrun, 0);
    runFrames(16'h0040, STABLE_SCANS + 1);
    tick();
    checkOutput("t6 re-report valid", key_if.key_valid, 1);
    checkOutput("t6 re-report code", key_if.key_code, (expQ.size() > 0) ? expQ[0] : -1);
    ackPulse();
    finishFrame();
    runFrames(16'h0000, 4);

    $display("[TB] random phase");
    autoAck = 1;
    obsQ.delete();
    expQ.delete();
    for (int s = 0; s < 24; s++) begin
      case ($urandom_range(0, 2))
        0: map = '0;
        1: map = 16'h0001 << $urandom_range(0, 15);
        default: begin
          a   = $urandom_range(0, 15);
          b   = (a + $urandom_range(1, 15)) % 16;
          map = (16'h0001 << a) | (16'h0001 << b);
        end
      endcase
      n = $urandom_range(1, 4);
      runFrames(map, n);
      checkOutput("rnd key_down", key_if.key_down, ($countones(debModel) == 1));
    end
    runFrames(16'h0000, 4);
    checkOutput("rnd event count", obsQ.size(), expQ.size());
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checkOutput("rnd event code", obsQ[i], expQ[i]);
    end
    checkOutput("rnd overrun", key_if.overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
